ex_stage: RTL

Execute stage of the five-stage integer pipeline, between the ID/EX and EX/MEM pipeline registers. It computes ALU, shift, move, multiply and HI/LO results combinationally from the operands latched by ID/EX. It runs DIV/DIVU on an iterative 32-step divider and raises a stall request until the quotient and remainder are ready.

---
 rtl/ex_stage_pkg.sv | 50 +++++
 rtl/ex_stage_if.sv | 34 +++
 rtl/ex_stage_div_iter.sv | 98 +++++++++
 rtl/ex_stage.sv | 135 +++++++++++++
 4 files changed

// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared opcodes, result classes and divider encodings for ex_stage
package ex_stage_pkg;

  localparam int AluOpWidth   = 8;
  localparam int AluSelWidth  = 3;
  localparam int RegAddrWidth = 5;
  localparam int WordWidth    = 32;

  localparam logic RstEnable         = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic [WordWidth-1:0] ZeroWord = 32'h0000_0000;

  localparam logic [AluSelWidth-1:0] EXE_RES_NOP        = 3'b000;
  localparam logic [AluSelWidth-1:0] EXE_RES_LOGIC      = 3'b001;
  localparam logic [AluSelWidth-1:0] EXE_RES_SHIFT      = 3'b010;
  localparam logic [AluSelWidth-1:0] EXE_RES_MOVE       = 3'b011;
  localparam logic [AluSelWidth-1:0] EXE_RES_ARITHMETIC = 3'b100;

  localparam logic [AluOpWidth-1:0] EXE_NOP_OP   = 8'b0000_0000;
  localparam logic [AluOpWidth-1:0] EXE_AND_OP   = 8'b0010_0100;
  localparam logic [AluOpWidth-1:0] EXE_OR_OP    = 8'b0010_0101;
  localparam logic [AluOpWidth-1:0] EXE_XOR_OP   = 8'b0010_0110;
  localparam logic [AluOpWidth-1:0] EXE_NOR_OP   = 8'b0010_0111;
  localparam logic [AluOpWidth-1:0] EXE_SLL_OP   = 8'b0111_1100;
  localparam logic [AluOpWidth-1:0] EXE_SRL_OP   = 8'b0000_0010;
  localparam logic [AluOpWidth-1:0] EXE_SRA_OP   = 8'b0000_0011;
  localparam logic [AluOpWidth-1:0] EXE_MFHI_OP  = 8'b0001_0000;
  localparam logic [AluOpWidth-1:0] EXE_MTHI_OP  = 8'b0001_0001;
  localparam logic [AluOpWidth-1:0] EXE_MFLO_OP  = 8'b0001_0010;
  localparam logic [AluOpWidth-1:0] EXE_MTLO_OP  = 8'b0001_0011;
  localparam logic [AluOpWidth-1:0] EXE_SLT_OP   = 8'b0010_1010;
  localparam logic [AluOpWidth-1:0] EXE_SLTU_OP  = 8'b0010_1011;
  localparam logic [AluOpWidth-1:0] EXE_ADD_OP   = 8'b0010_0000;
  localparam logic [AluOpWidth-1:0] EXE_ADDU_OP  = 8'b0010_0001;
  localparam logic [AluOpWidth-1:0] EXE_SUB_OP   = 8'b0010_0010;
  localparam logic [AluOpWidth-1:0] EXE_SUBU_OP  = 8'b0010_0011;
  localparam logic [AluOpWidth-1:0] EXE_MULT_OP  = 8'b0001_1000;
  localparam logic [AluOpWidth-1:0] EXE_MULTU_OP = 8'b0001_1001;
  localparam logic [AluOpWidth-1:0] EXE_DIV_OP   = 8'b0001_1010;
  localparam logic [AluOpWidth-1:0] EXE_DIVU_OP  = 8'b0001_1011;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'b00,
    DIV_ZERO = 2'b01,
    DIV_RUN  = 2'b10,
    DIV_DONE = 2'b11
  } div_state_e;

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX operand bundle in, EX/MEM write-back bundle out
interface ex_stage_if;
  import ex_stage_pkg::*;

  logic [AluSelWidth-1:0]  alusel;
  logic [AluOpWidth-1:0]   aluop;
  logic [WordWidth-1:0]    reg1_data;
  logic [WordWidth-1:0]    reg2_data;
  logic [RegAddrWidth-1:0] waddr;
  logic                    reg_we;
  logic [WordWidth-1:0]    inst;
  logic [WordWidth-1:0]    hi;
  logic [WordWidth-1:0]    lo;
  logic                    div_cancel;

  logic [WordWidth-1:0]    wb_wdata;
  logic [RegAddrWidth-1:0] wb_waddr;
  logic                    wb_reg_we;
  logic                    whilo;
  logic [WordWidth-1:0]    hi_out;
  logic [WordWidth-1:0]    lo_out;
  logic                    stallreq;

  modport master (
    output alusel, aluop, reg1_data, reg2_data, waddr, reg_we, inst, hi, lo, div_cancel,
    input  wb_wdata, wb_waddr, wb_reg_we, whilo, hi_out, lo_out, stallreq
  );

  modport slave (
    input  alusel, aluop, reg1_data, reg2_data, waddr, reg_we, inst, hi, lo, div_cancel,
    output wb_wdata, wb_waddr, wb_reg_we, whilo, hi_out, lo_out, stallreq
  );

endinterface

// File: rtl/ex_stage_div_iter.sv
// rtl/ex_stage_div_iter.sv - restoring iterative divider, present only when EX_DIV_EN is defined
`ifdef EX_DIV_EN
module div_iter
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div,
  input  logic [31:0] opdata1,
  input  logic [31:0] opdata2,
  input  logic        start,
  input  logic        cancel,
  output logic [63:0] result,
  output logic        ready
);

  localparam int CntW = $clog2(DIV_STEPS);
  localparam logic [CntW-1:0] LastStep = CntW'(DIV_STEPS - 1);

  div_state_e      state, state_n;
  logic [CntW-1:0] cnt;
  logic [64:0]     work;
  logic [31:0]     divisor_r;
  logic            neg_quo, neg_rem;
  logic [63:0]     result_r;

  logic [31:0] mag1, mag2;
  logic [64:0] shifted, work_step;
  logic [33:0] trial;
  logic [31:0] quo_fix, rem_fix;

  assign mag1 = (signed_div && opdata1[31]) ? -opdata1 : opdata1;
  assign mag2 = (signed_div && opdata2[31]) ? -opdata2 : opdata2;

  // Upper 33 bits hold the partial remainder with the next dividend bit shifted in.
  assign shifted   = {work[63:0], 1'b0};
  assign trial     = {1'b0, shifted[64:32]} - {2'b00, divisor_r};
  assign work_step = trial[33] ? shifted : {trial[32:0], shifted[31:1], 1'b1};
  assign quo_fix   = neg_quo ? -work_step[31:0]  : work_step[31:0];
  assign rem_fix   = neg_rem ? -work_step[63:32] : work_step[63:32];

  always_comb begin
    state_n = state;
    case (state)
      DIV_IDLE: if (start) state_n = (opdata2 == ZeroWord) ? DIV_ZERO : DIV_RUN;
      DIV_ZERO: state_n = DIV_DONE;
      DIV_RUN:  if (cnt == LastStep) state_n = DIV_DONE;
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
    if (cancel) state_n = DIV_IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      state <= DIV_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (rst == RstEnable) begin
      cnt       <= '0;
      work      <= '0;
      divisor_r <= ZeroWord;
      neg_quo   <= 1'b0;
      neg_rem   <= 1'b0;
      result_r  <= '0;
    end else begin
      case (state)
        DIV_IDLE: begin
          if (start && !cancel) begin
            cnt       <= '0;
            work      <= {33'b0, mag1};
            divisor_r <= mag2;
            neg_quo   <= signed_div & (opdata1[31] ^ opdata2[31]);
            neg_rem   <= signed_div & opdata1[31];
          end
        end
        DIV_ZERO: result_r <= '0;
        DIV_RUN: begin
          work <= work_step;
          cnt  <= cnt + 1'b1;
          if (cnt == LastStep) result_r <= {rem_fix, quo_fix};
        end
        default: ;
      endcase
    end
  end

  assign result = result_r;
  assign ready  = (state == DIV_DONE) ? DivResultReady : DivResultNotReady;

endmodule
`endif

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: ALU/shift/move/multiply, optional iterative divide under EX_DIV_EN
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int DIV_STEPS = 32
) (
  input logic       clk,
  input logic       rst,
  ex_stage_if.slave bus
);

  logic [31:0] r1, r2, sum, diff;
  logic        add_ovf, sub_ovf;
  logic [63:0] prod_s, prod_u;

  assign r1   = bus.reg1_data;
  assign r2   = bus.reg2_data;
  assign sum  = r1 + r2;
  assign diff = r1 - r2;
  assign add_ovf = (r1[31] == r2[31]) && (sum[31]  != r1[31]);
  assign sub_ovf = (r1[31] != r2[31]) && (diff[31] != r1[31]);
  assign prod_s  = {{32{r1[31]}}, r1} * {{32{r2[31]}}, r2};
  assign prod_u  = {32'b0, r1} * {32'b0, r2};

  logic [31:0] logic_res, shift_res, move_res, arith_res, hi_n, lo_n;
  logic        op_gpr, op_hilo, ovf;

`ifdef EX_DIV_EN
  logic        is_div, signed_div, div_start, div_ready;
  logic [63:0] div_result;
  logic        unused_ok;
  assign unused_ok = ^{bus.inst};
`else
  logic        unused_ok;
  assign unused_ok = ^{clk, bus.inst, bus.div_cancel, 32'(DIV_STEPS)};
`endif

  always_comb begin
    logic_res = ZeroWord;
    shift_res = ZeroWord;
    move_res  = ZeroWord;
    arith_res = ZeroWord;
    hi_n      = ZeroWord;
    lo_n      = ZeroWord;
    op_gpr    = 1'b0;
    op_hilo   = 1'b0;
    ovf       = 1'b0;
`ifdef EX_DIV_EN
    is_div     = 1'b0;
    signed_div = 1'b0;
`endif
    case (bus.aluop)
      EXE_OR_OP:   begin logic_res = r1 | r2;    op_gpr = 1'b1; end
      EXE_AND_OP:  begin logic_res = r1 & r2;    op_gpr = 1'b1; end
      EXE_XOR_OP:  begin logic_res = r1 ^ r2;    op_gpr = 1'b1; end
      EXE_NOR_OP:  begin logic_res = ~(r1 | r2); op_gpr = 1'b1; end
      EXE_SLL_OP:  begin shift_res = r2 << r1[4:0]; op_gpr = 1'b1; end
      EXE_SRL_OP:  begin shift_res = r2 >> r1[4:0]; op_gpr = 1'b1; end
      EXE_SRA_OP:  begin shift_res = $signed(r2) >>> r1[4:0]; op_gpr = 1'b1; end
      EXE_ADD_OP:  begin arith_res = sum;  ovf = add_ovf; op_gpr = 1'b1; end
      EXE_ADDU_OP: begin arith_res = sum;  op_gpr = 1'b1; end
      EXE_SUB_OP:  begin arith_res = diff; ovf = sub_ovf; op_gpr = 1'b1; end
      EXE_SUBU_OP: begin arith_res = diff; op_gpr = 1'b1; end
      EXE_SLT_OP:  begin arith_res = {31'b0, $signed(r1) < $signed(r2)}; op_gpr = 1'b1; end
      EXE_SLTU_OP: begin arith_res = {31'b0, r1 < r2}; op_gpr = 1'b1; end
      EXE_MFHI_OP: begin move_res = bus.hi; op_gpr = 1'b1; end
      EXE_MFLO_OP: begin move_res = bus.lo; op_gpr = 1'b1; end
      // MTHI/MTLO rewrite both halves so the untouched one keeps its forwarded value.
      EXE_MTHI_OP: begin op_hilo = 1'b1; hi_n = r1;     lo_n = bus.lo; end
      EXE_MTLO_OP: begin op_hilo = 1'b1; hi_n = bus.hi; lo_n = r1;     end
      EXE_MULT_OP:  begin op_hilo = 1'b1; hi_n = prod_s[63:32]; lo_n = prod_s[31:0]; end
      EXE_MULTU_OP: begin op_hilo = 1'b1; hi_n = prod_u[63:32]; lo_n = prod_u[31:0]; end
`ifdef EX_DIV_EN
      EXE_DIV_OP:  begin is_div = 1'b1; signed_div = 1'b1; end
      EXE_DIVU_OP: begin is_div = 1'b1; end
`endif
      default: ;
    endcase
  end

`ifdef EX_DIV_EN
  assign div_start = is_div & (div_ready == DivResultNotReady) & ~bus.div_cancel;

  div_iter #(
    .DIV_STEPS (DIV_STEPS)
  ) u_div_iter (
    .clk        (clk),
    .rst        (rst),
    .signed_div (signed_div),
    .opdata1    (r1),
    .opdata2    (r2),
    .start      (div_start),
    .cancel     (bus.div_cancel),
    .result     (div_result),
    .ready      (div_ready)
  );
`endif

  assign bus.wb_waddr = bus.waddr;

  always_comb begin
    bus.wb_wdata  = ZeroWord;
    bus.wb_reg_we = 1'b0;
    bus.whilo     = 1'b0;
    bus.hi_out    = ZeroWord;
    bus.lo_out    = ZeroWord;
    bus.stallreq  = 1'b0;
    if (rst != RstEnable) begin
      if (op_gpr) begin
        case (bus.alusel)
          EXE_RES_LOGIC:      bus.wb_wdata = logic_res;
          EXE_RES_SHIFT:      bus.wb_wdata = shift_res;
          EXE_RES_MOVE:       bus.wb_wdata = move_res;
          EXE_RES_ARITHMETIC: bus.wb_wdata = arith_res;
          default:            bus.wb_wdata = ZeroWord;
        endcase
        bus.wb_reg_we = bus.reg_we & ~ovf;
      end
      bus.whilo  = op_hilo;
      bus.hi_out = hi_n;
      bus.lo_out = lo_n;
`ifdef EX_DIV_EN
      if (is_div) begin
        bus.stallreq = (div_ready == DivResultNotReady);
        if (div_ready == DivResultReady) begin
          bus.whilo  = 1'b1;
          bus.hi_out = div_result[63:32];
          bus.lo_out = div_result[31:0];
        end
      end
`endif
    end
  end

endmodule
